lsu: RTL

- Load/store unit sitting between EXU and WBU in the multi-cycle NPC core.
- Accepts one instruction result from EXU and performs at most one memory access over an AXI-lite-style master port.
- Forms the final writeback value, then transmits the writeback bundle to WBU with a one-cycle `wbu_send_valid` pulse, which WBU consumes as `wbu_receive_valid`.

---
 rtl/lsu.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit between EXU and WBU: one optional memory access per instruction
// over an AXI-lite-style master port, then a one-cycle writeback pulse to WBU.
module lsu #(
    parameter int PASS_W = 133
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_send_valid,
    output logic              lsu_ready,
    input  logic [31:0]       alu_result,
    input  logic [31:0]       store_data,
    input  logic [2:0]        mem_op,
    input  logic              mem_ren,
    input  logic              mem_wen,
    input  logic [4:0]        rd,
    input  logic              reg_en,
    input  logic [PASS_W-1:0] passthru_i,
    output logic [31:0]       araddr,
    output logic              arvalid,
    input  logic              arready,
    input  logic [31:0]       rdata,
    input  logic [1:0]        rresp,
    input  logic              rvalid,
    output logic              rready,
    output logic [31:0]       awaddr,
    output logic              awvalid,
    input  logic              awready,
    output logic [31:0]       wdata,
    output logic [3:0]        wstrb,
    output logic              wvalid,
    input  logic              wready,
    input  logic [1:0]        bresp,
    input  logic              bvalid,
    output logic              bready,
    output logic              wbu_send_valid,
    output logic [4:0]        rd_o,
    output logic [31:0]       wd_o,
    output logic              reg_en_o,
    output logic [PASS_W-1:0] passthru_o,
    output logic              access_fault
);

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_W, S_B, S_SEND} state_t;

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_en_q, reg_en_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic              fault_q, fault_d;

    logic              lsu_ready_q, lsu_ready_d;
    logic [31:0]       araddr_q, araddr_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic [31:0]       awaddr_q, awaddr_d;
    logic              awvalid_q, awvalid_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              send_q, send_d;
    logic [4:0]        rd_o_q, rd_o_d;
    logic [31:0]       wd_o_q, wd_o_d;
    logic              reg_en_o_q, reg_en_o_d;
    logic [PASS_W-1:0] pass_o_q, pass_o_d;
    logic              fault_o_q, fault_o_d;

    logic        legal_ld, legal_st, misaligned, bad_access;
    logic [31:0] ld_shift, ld_ext;

    // Decode of the incoming instruction; only meaningful in IDLE on accept.
    assign legal_ld   = mem_op inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    assign legal_st   = mem_op inside {3'b000, 3'b001, 3'b010};
    assign misaligned = (mem_op[1:0] == 2'b01 && alu_result[0]) ||
                        (mem_op[1:0] == 2'b10 && alu_result[1:0] != 2'b00);
    assign bad_access = (mem_ren && mem_wen) || (mem_ren && !legal_ld) ||
                        (mem_wen && !legal_st) || ((mem_ren || mem_wen) && misaligned);

    assign ld_shift = rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        ld_ext = ld_shift;
        case (op_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b100:  ld_ext = {24'h0, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b101:  ld_ext = {16'h0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        op_d       = op_q;
        rd_d       = rd_q;
        reg_en_d   = reg_en_q;
        pass_d     = pass_q;
        fault_d    = fault_q;
        araddr_d   = araddr_q;
        arvalid_d  = arvalid_q;
        rready_d   = rready_q;
        awaddr_d   = awaddr_q;
        awvalid_d  = awvalid_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wvalid_d   = wvalid_q;
        bready_d   = bready_q;
        send_d     = 1'b0;
        rd_o_d     = rd_o_q;
        wd_o_d     = wd_o_q;
        reg_en_o_d = reg_en_o_q;
        pass_o_d   = pass_o_q;
        fault_o_d  = fault_o_q;

        case (state_q)
            S_IDLE: begin
                if (exu_send_valid) begin
                    addr_d   = alu_result;
                    op_d     = mem_op;
                    rd_d     = rd;
                    reg_en_d = reg_en;
                    pass_d   = passthru_i;
                    fault_d  = bad_access;
                    if (bad_access || !(mem_ren || mem_wen)) begin
                        state_d    = S_SEND;
                        send_d     = 1'b1;
                        rd_o_d     = rd;
                        wd_o_d     = alu_result;
                        reg_en_o_d = reg_en && !bad_access;
                        pass_o_d   = passthru_i;
                        fault_o_d  = bad_access;
                    end else if (mem_ren) begin
                        state_d   = S_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = alu_result;
                    end else begin
                        state_d   = S_W;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = alu_result;
                        wdata_d   = store_data << {alu_result[1:0], 3'b000};
                        case (mem_op[1:0])
                            2'b00:   wstrb_d = 4'b0001 << alu_result[1:0];
                            2'b01:   wstrb_d = 4'b0011 << alu_result[1:0];
                            default: wstrb_d = 4'b1111;
                        endcase
                    end
                end
            end
            S_AR: begin
                if (arready) begin
                    state_d   = S_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            S_R: begin
                if (rvalid) begin
                    state_d    = S_SEND;
                    rready_d   = 1'b0;
                    send_d     = 1'b1;
                    rd_o_d     = rd_q;
                    wd_o_d     = ld_ext;
                    reg_en_o_d = reg_en_q && (rresp == 2'b00);
                    pass_o_d   = pass_q;
                    fault_o_d  = (rresp != 2'b00);
                end
            end
            S_W: begin
                // Address and data channels complete independently in either order.
                awvalid_d = awvalid_q && !awready;
                wvalid_d  = wvalid_q && !wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = S_B;
                    bready_d = 1'b1;
                end
            end
            S_B: begin
                if (bvalid) begin
                    state_d    = S_SEND;
                    bready_d   = 1'b0;
                    send_d     = 1'b1;
                    rd_o_d     = rd_q;
                    wd_o_d     = addr_q;
                    reg_en_o_d = reg_en_q && (bresp == 2'b00);
                    pass_o_d   = pass_q;
                    fault_o_d  = (bresp != 2'b00);
                end
            end
            default: state_d = S_IDLE;
        endcase

        lsu_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            reg_en_q    <= 1'b0;
            pass_q      <= '0;
            fault_q     <= 1'b0;
            lsu_ready_q <= 1'b1;
            araddr_q    <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            awaddr_q    <= '0;
            awvalid_q   <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            send_q      <= 1'b0;
            rd_o_q      <= '0;
            wd_o_q      <= '0;
            reg_en_o_q  <= 1'b0;
            pass_o_q    <= '0;
            fault_o_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            reg_en_q    <= reg_en_d;
            pass_q      <= pass_d;
            fault_q     <= fault_d;
            lsu_ready_q <= lsu_ready_d;
            araddr_q    <= araddr_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            awaddr_q    <= awaddr_d;
            awvalid_q   <= awvalid_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            send_q      <= send_d;
            rd_o_q      <= rd_o_d;
            wd_o_q      <= wd_o_d;
            reg_en_o_q  <= reg_en_o_d;
            pass_o_q    <= pass_o_d;
            fault_o_q   <= fault_o_d;
        end
    end

    assign lsu_ready      = lsu_ready_q;
    assign araddr         = araddr_q;
    assign arvalid        = arvalid_q;
    assign rready         = rready_q;
    assign awaddr         = awaddr_q;
    assign awvalid        = awvalid_q;
    assign wdata          = wdata_q;
    assign wstrb          = wstrb_q;
    assign wvalid         = wvalid_q;
    assign bready         = bready_q;
    assign wbu_send_valid = send_q;
    assign rd_o           = rd_o_q;
    assign wd_o           = wd_o_q;
    assign reg_en_o       = reg_en_o_q;
    assign passthru_o     = pass_o_q;
    assign access_fault   = fault_o_q;

endmodule
